sha256_compress: RTL and testbench
==================================

// Module: sha256_compress
// PURPOSE
//  Consumer end of the message-schedule interface: reads the 64-word W vector produced by the
//  schedule expander and runs the 64 SHA-256 compression rounds over it, one round per cycle.
//  Adds the working variables to the chaining hash (feed-forward) and presents the 256-bit digest.
//  Sits between the schedule expander and the top-level block sequencer, which chains multi-block messages.
// PARAMETERS
//  W_LENGTH    64   number of schedule words / rounds; sizes the round counter ($clog2(W_LENGTH) bits)
// PORTS
//  clock               in   1     single clock; all state on rising edge
//  reset               in   1     asynchronous, active-low reset
//  enable              in   1     W vector valid (driven by the expander's w_vector_complete)
//  w_vector            in   2048  W[0..63]; W[t] = w_vector[2047-32*t -: 32] (W[0] at MSBs)
//  hash_in             in   256   chaining value H0..H7, H0 at [255:224]
//  busy                out  1     high while a block is being compressed
//  hash_complete       out  1     one-cycle pulse: hash_out updated
//  hash_out            out  256   digest / next chaining value, H0 at [255:224]
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, busy=0, hash_complete=0, hash_out=0, counter=0, a..h=0.
//  - FSM: IDLE -> ROUND -> FINAL -> IDLE.
//  - IDLE: on edge with enable==1 (accept edge E0): latch w_vector and hash_in into internal regs,
//    load a..h <= hash_in, t <= 0, busy <= 1, go ROUND. Inputs are don't-care after E0.
//  - ROUND: each edge applies round t with K[t] and latched W[t]; t increments; after round 63
//    (edge E64) go FINAL. Counter never wraps: t==W_LENGTH-1 forces FINAL.
//  - FINAL (edge E65): hash_out[i] <= H[i] + var[i] (mod 2^32, per word, carries discarded),
//    hash_complete <= 1 for exactly that cycle, busy <= 0, go IDLE.
//  - Latency: hash_complete high in the cycle after edge E65 (65 cycles after accept).
//    Back-to-back: enable may be high in that same cycle; accepted on the next edge.
//  - enable while busy: ignored, no queueing, no error. hash_out holds until the next FINAL.
//  - Round math: T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = S0(a) + Maj(a,b,c);
//    h..a <= g,f,e,d+T1,c,b,a,T1+T2; all sums mod 2^32.
//  - Reset asserted mid-block: everything returns to reset values immediately; the block is lost;
//    hash_complete never fires for it.
// CONFIGURATION
//  - COMPRESS_UNROLL2_EN defined: two rounds per cycle (t steps by 2; rounds 2k and 2k+1 chained
//    combinationally). ROUND lasts 32 edges, FINAL at E33, latency 33 cycles. Requires even W_LENGTH.
//  - Not defined: one round per cycle, latency 65 as above. Ports and digest identical in both.
// STRUCTURE
//  - Shared package sha256_pkg: K[0:63] constant table, IV H0..H7 constants, FSM state typedef,
//    functions ch, maj, bsig0, bsig1 (Sigma0/1). The expander also imports it.
//  - One sub-module: sha256_round (combinational: a..h, K, W in -> a..h out); instantiated once,
//    or twice in series under COMPRESS_UNROLL2_EN.
// TESTING
//  - "abc" padded block, hash_in=IV -> hash_out=ba7816bf 8f01cfea 414140de 5dae2223
//    b00361a3 96177a9c b410ff61 f20015ad; hash_complete exactly 65 cycles after accept (33 unrolled).
//  - Empty message block, hash_in=IV -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c
//    a495991b 7852b855.
//  - Two-block "abcdbcdecdefghij...nopq" (56 bytes) chained via hash_out->hash_in ->
//    248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  - enable pulsed and w_vector/hash_in scrambled at round 10 -> ignored; "abc" digest unchanged.
//  - reset driven low at round 30 -> busy=0, hash_out=0 asynchronously; no hash_complete;
//    fresh "abc" afterwards gives correct digest.
//  - enable held high continuously -> new block accepted on the edge after each hash_complete;
//    three consecutive digests all correct.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, IV, FSM state type and round helper functions
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  typedef logic [7:0][31:0] word8_t;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
endpackage

// File: rtl/sha256_compress_if.sv
// sha256_compress_if: schedule-in / digest-out bus between expander, compressor and sequencer
interface sha256_compress_if;
  logic enable;
  logic [2047:0] w_vector;
  logic [255:0] hash_in;
  logic busy;
  logic hash_complete;
  logic [255:0] hash_out;
  modport master (output enable, w_vector, hash_in, input busy, hash_complete, hash_out);
  modport slave (input enable, w_vector, hash_in, output busy, hash_complete, hash_out);
endinterface

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round; word 7 is a, word 0 is h
module sha256_round import sha256_pkg::*; (
  input word8_t v,
  input logic [31:0] k,
  input logic [31:0] w,
  output word8_t v_n
);
  logic [31:0] t1, t2;
  always_comb begin
    t1 = v[0] + bsig1(v[3]) + ch(v[3], v[2], v[1]) + k + w;
    t2 = bsig0(v[7]) + maj(v[7], v[6], v[5]);
    v_n = {t1 + t2, v[7], v[6], v[5], v[4] + t1, v[3], v[2], v[1]};
  end
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: 64-round SHA-256 compression with feed-forward; one round per cycle,
// or two per cycle when COMPRESS_UNROLL2_EN is defined.
module sha256_compress import sha256_pkg::*; #(
  parameter int W_LENGTH = 64
) (
  input logic clock,
  input logic reset,
  sha256_compress_if.slave bus
);
  localparam int CW = $clog2(W_LENGTH);
`ifdef COMPRESS_UNROLL2_EN
  localparam logic [CW-1:0] STEP = CW'(2);
`else
  localparam logic [CW-1:0] STEP = CW'(1);
`endif
  localparam logic [CW-1:0] LAST = CW'(W_LENGTH) - STEP;
  state_t state, state_n;
  logic [CW-1:0] t;
  logic [0:W_LENGTH-1][31:0] w_reg;
  word8_t h_reg, vars, vars_n, r0, digest, hash_out;
  logic busy, hash_complete;
  sha256_round u_r0 (.v(vars), .k(K[t]), .w(w_reg[t]), .v_n(r0));
`ifdef COMPRESS_UNROLL2_EN
  logic [CW-1:0] t1;
  assign t1 = t + CW'(1);
  sha256_round u_r1 (.v(r0), .k(K[t1]), .w(w_reg[t1]), .v_n(vars_n));
`else
  assign vars_n = r0;
`endif
  always_comb begin
    state_n = state == IDLE ? (bus.enable ? ROUND : IDLE) :
              state == ROUND ? (t == LAST ? FINAL : ROUND) : IDLE;
    for (int i = 0; i < 8; i++) digest[i] = h_reg[i] + vars[i];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      t <= '0;
      w_reg <= '0;
      h_reg <= '0;
      vars <= '0;
      hash_out <= '0;
      busy <= 1'b0;
      hash_complete <= 1'b0;
    end else begin
      state <= state_n;
      hash_complete <= state == FINAL;
      if (state == IDLE && bus.enable) begin
        w_reg <= bus.w_vector;
        h_reg <= bus.hash_in;
        vars <= bus.hash_in;
        t <= '0;
        busy <= 1'b1;
      end
      if (state == ROUND) begin
        vars <= vars_n;
        t <= t + STEP;
      end
      if (state == FINAL) begin
        hash_out <= digest;
        busy <= 1'b0;
      end
    end
  assign bus.busy = busy;
  assign bus.hash_complete = hash_complete;
  assign bus.hash_out = hash_out;
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: directed known-answer vectors, latency, ignore-while-busy, reset and back-to-back
module tb_sha256_compress;
`ifdef COMPRESS_UNROLL2_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif
  localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h18};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_M1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_M2 = {480'h0, 32'h1c0};
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  logic [255:0] dig, mid;
  int lat, pulses;
  sha256_compress_if bus ();
  sha256_compress dut (.clock(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [2047:0] expand(input logic [511:0] m);
    logic [31:0] w [64];
    logic [2047:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) r[2047 - 32 * i -: 32] = w[i];
    return r;
  endfunction
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Call just after an edge; returns digest and edges from accept to hash_complete.
  task automatic run(input logic [511:0] blk, input logic [255:0] hin, input string tag,
                     input int scramble, input bit keep_en, output logic [255:0] d, output int n);
    bus.w_vector = expand(blk);
    bus.hash_in = hin;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_en) bus.enable = 1'b0;
    check({tag, " busy"}, {255'h0, bus.busy}, 256'h1);
    n = 1;
    while (n < 200) begin
      if (n == scramble) begin
        bus.enable = 1'b1;
        bus.w_vector = {64{32'($urandom)}};
        bus.hash_in = {8{32'($urandom)}};
      end
      if (n == scramble + 1) bus.enable = 1'b0;
      @(posedge clk);
      #1;
      if (bus.hash_complete) break;
      n++;
    end
    d = bus.hash_out;
    check({tag, " latency"}, 256'(n), 256'(LAT));
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.w_vector = '0;
    bus.hash_in = '0;
    #12;
    check("reset busy", {255'h0, bus.busy}, 256'h0);
    check("reset complete", {255'h0, bus.hash_complete}, 256'h0);
    check("reset hash_out", bus.hash_out, 256'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run(B_ABC, H0, "abc", -1, 1'b0, dig, lat);
    check("abc digest", dig, D_ABC);
    @(posedge clk);
    #1;
    check("abc pulse width", {255'h0, bus.hash_complete}, 256'h0);
    check("abc busy after", {255'h0, bus.busy}, 256'h0);
    check("abc hash_out hold", bus.hash_out, D_ABC);
    run(B_EMPTY, H0, "empty", -1, 1'b0, dig, lat);
    check("empty digest", dig, D_EMPTY);
    run(B_M1, H0, "two blk1", -1, 1'b0, mid, lat);
    run(B_M2, mid, "two blk2", -1, 1'b0, dig, lat);
    check("two digest", dig, D_TWO);
    run(B_ABC, H0, "scramble", 10, 1'b0, dig, lat);
    check("scramble digest", dig, D_ABC);
    bus.w_vector = expand(B_ABC);
    bus.hash_in = H0;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset busy", {255'h0, bus.busy}, 256'h0);
    check("midreset hash_out", bus.hash_out, 256'h0);
    check("midreset complete", {255'h0, bus.hash_complete}, 256'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.hash_complete) pulses++;
    end
    check("midreset no pulse", 256'(pulses), 256'h0);
    run(B_ABC, H0, "post reset", -1, 1'b0, dig, lat);
    check("post reset digest", dig, D_ABC);
    run(B_ABC, H0, "b2b 1", -1, 1'b1, dig, lat);
    check("b2b 1 digest", dig, D_ABC);
    run(B_EMPTY, H0, "b2b 2", -1, 1'b1, dig, lat);
    check("b2b 2 digest", dig, D_EMPTY);
    run(B_ABC, H0, "b2b 3", -1, 1'b1, dig, lat);
    check("b2b 3 digest", dig, D_ABC);
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    check("b2b pulse width", {255'h0, bus.hash_complete}, 256'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
